// File: rtl/rast_pkg.sv
// Shared types and field positions for the line rasterizer sequencer.
package rast_pkg;

  localparam int COORD_W = 10;
  localparam int DELTA_W = 11;
  localparam int ERR_W   = 13;
  localparam int COLOR_W = 4;
  localparam int CMD_W   = 44;

  localparam int X0_LSB    = 34;
  localparam int Y0_LSB    = 24;
  localparam int X1_LSB    = 14;
  localparam int Y1_LSB    = 4;
  localparam int COLOR_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/line_delta_setup.sv
// Combinational Bresenham setup: absolute deltas, step directions and initial error.
module line_delta_setup
  import rast_pkg::*;
(
  input  logic [COORD_W-1:0]      x0,
  input  logic [COORD_W-1:0]      y0,
  input  logic [COORD_W-1:0]      x1,
  input  logic [COORD_W-1:0]      y1,
  output logic [DELTA_W-1:0]      adx,
  output logic [DELTA_W-1:0]      ady,
  output logic                    sx_neg,
  output logic                    sy_neg,
  output logic signed [ERR_W-1:0] err_init
);

  logic [DELTA_W-1:0] dx;
  logic [DELTA_W-1:0] dy;

  assign dx     = {1'b0, x1} - {1'b0, x0};
  assign dy     = {1'b0, y1} - {1'b0, y0};
  assign sx_neg = dx[DELTA_W-1];
  assign sy_neg = dy[DELTA_W-1];
  assign adx    = sx_neg ? (~dx + 1'b1) : dx;
  assign ady    = sy_neg ? (~dy + 1'b1) : dy;

  // Deltas are at most 1023, so zero extension keeps them positive in the error width.
  assign err_init = $signed({{(ERR_W-DELTA_W){1'b0}}, adx})
                  - $signed({{(ERR_W-DELTA_W){1'b0}}, ady});

endmodule

// File: rtl/line_raster_ctrl.sv
// Line command to pixel stream sequencer using Bresenham stepping.
// Optional clipping to SCREEN_W x SCREEN_H is compiled in with LINE_RASTER_CLIP_EN.
//
// state | meaning
// IDLE  | waiting for a command, line_ready high
// SETUP | deltas and initial error registered, point set to start
// DRAW  | presenting current point, stepping on transfer
// DONE  | one-cycle line_done pulse
module line_raster_ctrl
  import rast_pkg::*;
#(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CMD_W-1:0]     line_cap_reg,
  input  logic                 line_valid,
  output logic                 line_ready,
  output logic [COORD_W-1:0]   pix_x,
  output logic [COORD_W-1:0]   pix_y,
  output logic [COLOR_W-1:0]   pix_color,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 busy,
  output logic                 line_done
);

  state_t state, state_nxt;

  logic [COORD_W-1:0]      x0_q, y0_q, x1_q, y1_q;
  logic [COORD_W-1:0]      cur_x, cur_y;
  logic [COLOR_W-1:0]      color_q;
  logic [DELTA_W-1:0]      adx_q, ady_q;
  logic                    sx_neg_q, sy_neg_q;
  logic signed [ERR_W-1:0] err_q;

  logic [DELTA_W-1:0]      adx_c, ady_c;
  logic                    sx_neg_c, sy_neg_c;
  logic signed [ERR_W-1:0] err_init_c;

  logic signed [ERR_W-1:0] adx_s, ady_s, e2, err_nxt;
  logic                    step_x, step_y, at_end, visible, advance;

  line_delta_setup u_setup (
    .x0       (x0_q),
    .y0       (y0_q),
    .x1       (x1_q),
    .y1       (y1_q),
    .adx      (adx_c),
    .ady      (ady_c),
    .sx_neg   (sx_neg_c),
    .sy_neg   (sy_neg_c),
    .err_init (err_init_c)
  );

  assign adx_s   = $signed({{(ERR_W-DELTA_W){1'b0}}, adx_q});
  assign ady_s   = $signed({{(ERR_W-DELTA_W){1'b0}}, ady_q});
  assign e2      = err_q <<< 1;
  assign step_x  = (e2 >= -ady_s);
  assign step_y  = (e2 <= adx_s);
  assign err_nxt = err_q - (step_x ? ady_s : '0) + (step_y ? adx_s : '0);
  assign at_end  = (cur_x == x1_q) && (cur_y == y1_q);

`ifdef LINE_RASTER_CLIP_EN
  assign visible = (32'(cur_x) < SCREEN_W) && (32'(cur_y) < SCREEN_H);
`else
  logic unused_screen;
  assign unused_screen = ^{SCREEN_W[0], SCREEN_H[0]};
  assign visible       = 1'b1;
`endif

  // Clipped points step on their own; visible points wait for the framebuffer.
  assign advance = (state == DRAW) && (pix_ready || !visible);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (line_valid) state_nxt = SETUP;
      SETUP:   state_nxt = DRAW;
      DRAW:    if (advance && at_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    line_ready = (state == IDLE);
    busy       = (state != IDLE);
    line_done  = (state == DONE);
    pix_valid  = (state == DRAW) && visible;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      color_q  <= '0;
      adx_q    <= '0;
      ady_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      err_q    <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
    end else begin
      if (state == IDLE && line_valid) begin
        x0_q    <= line_cap_reg[X0_LSB +: COORD_W];
        y0_q    <= line_cap_reg[Y0_LSB +: COORD_W];
        x1_q    <= line_cap_reg[X1_LSB +: COORD_W];
        y1_q    <= line_cap_reg[Y1_LSB +: COORD_W];
        color_q <= line_cap_reg[COLOR_LSB +: COLOR_W];
      end
      if (state == SETUP) begin
        adx_q    <= adx_c;
        ady_q    <= ady_c;
        sx_neg_q <= sx_neg_c;
        sy_neg_q <= sy_neg_c;
        err_q    <= err_init_c;
        cur_x    <= x0_q;
        cur_y    <= y0_q;
      end
      if (advance && !at_end) begin
        err_q <= err_nxt;
        if (step_x) cur_x <= sx_neg_q ? cur_x - 1'b1 : cur_x + 1'b1;
        if (step_y) cur_y <= sy_neg_q ? cur_y - 1'b1 : cur_y + 1'b1;
      end
    end
  end

  assign pix_x     = cur_x;
  assign pix_y     = cur_y;
  assign pix_color = color_q;

endmodule

// File: tb/tb_line_raster_ctrl.sv
// Directed and randomized bench for line_raster_ctrl against an integer line model.
module tb_line_raster_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [43:0] line_cap_reg;
  logic        line_valid;
  logic        line_ready;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [3:0]  pix_color;
  logic        pix_valid;
  logic        pix_ready;
  logic        busy;
  logic        line_done;

  int checks = 0;
  int errors = 0;

  int exp_x[$];
  int exp_y[$];

  line_raster_ctrl #(.SCREEN_W(640), .SCREEN_H(480)) dut (
    .clk          (clk),
    .rst          (rst),
    .line_cap_reg (line_cap_reg),
    .line_valid   (line_valid),
    .line_ready   (line_ready),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_color    (pix_color),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .busy         (busy),
    .line_done    (line_done)
  );

  always #5 clk = ~clk;

`define CHK(tag, obs, exp) begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s observed=%0d expected=%0d", tag, (obs), (exp)); \
    end \
  end

  // Expected presented points of a line: plain integer walk from start to end.
  function automatic void build_model(int x0, int y0, int x1, int y1);
    int x, y, dx, dy, sx, sy, err, e2;
    exp_x.delete();
    exp_y.delete();
    dx  = (x1 >= x0) ? x1 - x0 : x0 - x1;
    dy  = (y1 >= y0) ? y1 - y0 : y0 - y1;
    sx  = (x1 >= x0) ? 1 : -1;
    sy  = (y1 >= y0) ? 1 : -1;
    err = dx - dy;
    x   = x0;
    y   = y0;
    forever begin
`ifdef LINE_RASTER_CLIP_EN
      if (x < 640 && y < 480) begin
        exp_x.push_back(x);
        exp_y.push_back(y);
      end
`else
      exp_x.push_back(x);
      exp_y.push_back(y);
`endif
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= -dy) begin err -= dy; x += sx; end
      if (e2 <= dx)  begin err += dx; y += sy; end
    end
  endfunction

  // mode 0: ready always, 1: ready 1,0,0 repeating, 2: random ready.
  // abort_at >= 0 asserts reset while that pixel index is presented.
  task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                          input int c, input int mode, input bit chk_first,
                          input int abort_at);
    int  idx, last_xfer, k;
    bit  rdy, done_seen;
    build_model(x0, y0, x1, y1);
    @(negedge clk);
    k = 0;
    while (!line_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    `CHK("line_ready_before_cmd", line_ready, 1'b1)
    line_cap_reg = {10'(x0), 10'(y0), 10'(x1), 10'(y1), 4'(c)};
    line_valid   = 1'b1;
    @(negedge clk);
    line_valid   = 1'b0;
    line_cap_reg = 44'(64'($urandom) << 12);
    `CHK("setup_busy", busy, 1'b1)
    `CHK("setup_no_valid", pix_valid, 1'b0)
    `CHK("setup_not_ready", line_ready, 1'b0)
    idx       = 0;
    last_xfer = -10;
    done_seen = 1'b0;
    for (int cyc = 2; cyc < 5000 && !done_seen; cyc++) begin
      @(negedge clk);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc - 2) % 3) == 0;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      pix_ready = rdy;
      if (cyc == 2 && chk_first) `CHK("first_valid_latency", pix_valid, 1'b1)
      if (abort_at >= 0 && idx == abort_at && pix_valid) begin
        rst = 1'b1;
        #1;
        `CHK("abort_pix_valid", pix_valid, 1'b0)
        `CHK("abort_busy", busy, 1'b0)
        `CHK("abort_line_done", line_done, 1'b0)
        `CHK("abort_line_ready", line_ready, 1'b1)
        @(negedge clk);
        rst = 1'b0;
        `CHK("abort_no_done_after", line_done, 1'b0)
        return;
      end
      if (line_done) begin
        done_seen = 1'b1;
        `CHK("done_busy", busy, 1'b1)
        `CHK("pixel_count", idx, exp_x.size())
`ifndef LINE_RASTER_CLIP_EN
        `CHK("done_after_last_xfer", cyc, last_xfer + 1)
`endif
      end else if (pix_valid) begin
        if (idx < exp_x.size()) begin
          `CHK("pix_x", int'(pix_x), exp_x[idx])
          `CHK("pix_y", int'(pix_y), exp_y[idx])
          `CHK("pix_color", int'(pix_color), c)
        end else begin
          `CHK("extra_pixel", idx, exp_x.size())
        end
        if (rdy) begin
          idx++;
          last_xfer = cyc;
        end
      end else begin
`ifndef LINE_RASTER_CLIP_EN
        `CHK("valid_in_draw", pix_valid, 1'b1)
`endif
        `CHK("busy_in_draw", busy, 1'b1)
      end
    end
    `CHK("line_done_seen", done_seen, 1'b1)
    pix_ready = 1'b0;
    @(negedge clk);
    `CHK("done_is_pulse", line_done, 1'b0)
    `CHK("ready_after_done", line_ready, 1'b1)
    `CHK("idle_not_busy", busy, 1'b0)
  endtask

  initial begin
    rst          = 1'b1;
    line_valid   = 1'b0;
    pix_ready    = 1'b0;
    line_cap_reg = '0;
    repeat (3) @(negedge clk);
    `CHK("rst_line_ready", line_ready, 1'b1)
    `CHK("rst_pix_valid", pix_valid, 1'b0)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_line_done", line_done, 1'b0)
    `CHK("rst_pix_x", int'(pix_x), 0)
    `CHK("rst_pix_y", int'(pix_y), 0)
    `CHK("rst_pix_color", int'(pix_color), 0)
    rst = 1'b0;

    run_line(0, 0, 5, 0, 3, 0, 1'b1, -1);
    run_line(10, 10, 7, 2, 9, 0, 1'b1, -1);
    run_line(100, 200, 100, 200, 12, 0, 1'b1, -1);
    run_line(0, 0, 3, 3, 5, 1, 1'b1, -1);
    run_line(0, 0, 20, 0, 7, 0, 1'b1, 2);
    run_line(5, 5, 6, 6, 1, 0, 1'b1, -1);
`ifdef LINE_RASTER_CLIP_EN
    run_line(636, 0, 643, 0, 2, 0, 1'b1, -1);
`endif

    for (int n = 0; n < 10; n++) begin
      int rx0, ry0, rx1, ry1;
      rx0 = $urandom_range(0, 1023);
      ry0 = $urandom_range(0, 1023);
      if (n < 5) begin
        rx1 = $urandom_range(0, 63);
        ry1 = $urandom_range(0, 63);
        rx0 = rx0 % 64;
        ry0 = ry0 % 64;
      end else begin
        rx1 = $urandom_range(0, 1023);
        ry1 = $urandom_range(0, 1023);
      end
      run_line(rx0, ry0, rx1, ry1, $urandom_range(0, 15), 2, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
